// File: rtl/cdb_arbiter_if.sv
// Producer-side handshakes and the registered CDB broadcast of cdb_arbiter.
// The arbiter takes the slave view; the producers and consumers take the master view.
interface cdb_arbiter_if #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  // ALU/branch producer
  logic              alu_valid_in;
  logic              alu_ready_out;
  logic [TAG_W-1:0]  alu_tag_in;
  logic [DATA_W-1:0] alu_data_in;
  logic              alu_jump_in;
  logic [ADDR_W-1:0] alu_target_in;

  // Load producer
  logic              lsb_valid_in;
  logic              lsb_ready_out;
  logic [TAG_W-1:0]  lsb_tag_in;
  logic [DATA_W-1:0] lsb_data_in;

  // Broadcast to ROB, RS, LSB and regfile
  logic              cdb_valid_out;
  logic              cdb_src_out;
  logic [TAG_W-1:0]  cdb_tag_out;
  logic [DATA_W-1:0] cdb_data_out;
  logic              cdb_jump_out;
  logic [ADDR_W-1:0] cdb_target_out;

  modport master (
    output alu_valid_in, alu_tag_in, alu_data_in, alu_jump_in, alu_target_in,
    output lsb_valid_in, lsb_tag_in, lsb_data_in,
    input  alu_ready_out, lsb_ready_out,
    input  cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out,
    input  cdb_jump_out, cdb_target_out
  );

  modport slave (
    input  alu_valid_in, alu_tag_in, alu_data_in, alu_jump_in, alu_target_in,
    input  lsb_valid_in, lsb_tag_in, lsb_data_in,
    output alu_ready_out, lsb_ready_out,
    output cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out,
    output cdb_jump_out, cdb_target_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Two-producer CDB arbiter: per-source holding FIFOs, round-robin grant and a
// registered broadcast; a ROB clear empties both FIFOs.
module cdb_arbiter #(
  parameter int TAG_W  = 5,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          rdy_in,
  input  logic          clear_in,
  cdb_arbiter_if.slave  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } src_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } alu_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } lsb_entry_t;

  alu_entry_t       alu_mem [DEPTH];
  lsb_entry_t       lsb_mem [DEPTH];
  logic [PTR_W-1:0] alu_head, alu_tail, lsb_head, lsb_tail;
  logic [CNT_W-1:0] alu_count, lsb_count;
  src_e             last_grant;

  logic       active;
  logic       alu_ready, lsb_ready;
  logic       alu_push, lsb_push;
  logic       alu_pop, lsb_pop;
  logic       alu_nonempty, lsb_nonempty;
  logic       grant_valid;
  src_e       grant_src;
  alu_entry_t grant_entry;

  // Readies come from registered state plus the two global controls only.
  assign active    = rdy_in & ~clear_in;
  assign alu_ready = active & (alu_count < FULL_CNT);
  assign lsb_ready = active & (lsb_count < FULL_CNT);

  assign bus.alu_ready_out = alu_ready;
  assign bus.lsb_ready_out = lsb_ready;

  assign alu_push     = bus.alu_valid_in & alu_ready;
  assign lsb_push     = bus.lsb_valid_in & lsb_ready;
  assign alu_nonempty = (alu_count != '0);
  assign lsb_nonempty = (lsb_count != '0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves a signal unassigned and a latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_src   = SRC_ALU;
    if (active) begin
      unique case ({alu_nonempty, lsb_nonempty})
        2'b11: begin
          grant_valid = 1'b1;
          grant_src   = (last_grant == SRC_LSB) ? SRC_ALU : SRC_LSB;
        end
        2'b10: begin
          grant_valid = 1'b1;
          grant_src   = SRC_ALU;
        end
        2'b01: begin
          grant_valid = 1'b1;
          grant_src   = SRC_LSB;
        end
        default: ;
      endcase
    end
  end

  assign alu_pop = grant_valid & (grant_src == SRC_ALU);
  assign lsb_pop = grant_valid & (grant_src == SRC_LSB);

  // Load results have no jump/target; they are zero-filled on the way out.
  always_comb begin
    grant_entry = alu_mem[alu_head];
    if (grant_src == SRC_LSB) begin
      grant_entry.tag    = lsb_mem[lsb_head].tag;
      grant_entry.data   = lsb_mem[lsb_head].data;
      grant_entry.jump   = 1'b0;
      grant_entry.target = '0;
    end
  end

  // NOTE: the storage arrays carry no reset; an entry is only ever read while
  // its count says it is valid, so reset value would be dead logic.
  always_ff @(posedge clk_in) begin
    if (alu_push) begin
      alu_mem[alu_tail] <= {bus.alu_tag_in, bus.alu_data_in,
                            bus.alu_jump_in, bus.alu_target_in};
    end
    if (lsb_push) begin
      lsb_mem[lsb_tail] <= {bus.lsb_tag_in, bus.lsb_data_in};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_head  <= '0;
      alu_tail  <= '0;
      alu_count <= '0;
      lsb_head  <= '0;
      lsb_tail  <= '0;
      lsb_count <= '0;
    end else if (clear_in) begin
      alu_head  <= '0;
      alu_tail  <= '0;
      alu_count <= '0;
      lsb_head  <= '0;
      lsb_tail  <= '0;
      lsb_count <= '0;
    end else begin
      if (alu_push) alu_tail <= alu_tail + 1'b1;
      if (alu_pop)  alu_head <= alu_head + 1'b1;
      if (lsb_push) lsb_tail <= lsb_tail + 1'b1;
      if (lsb_pop)  lsb_head <= lsb_head + 1'b1;
      unique case ({alu_push, alu_pop})
        2'b10:   alu_count <= alu_count + 1'b1;
        2'b01:   alu_count <= alu_count - 1'b1;
        default: alu_count <= alu_count;
      endcase
      unique case ({lsb_push, lsb_pop})
        2'b10:   lsb_count <= lsb_count + 1'b1;
        2'b01:   lsb_count <= lsb_count - 1'b1;
        default: lsb_count <= lsb_count;
      endcase
    end
  end

  // The ALU wins the first tie after reset; a clear leaves fairness history alone.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant <= SRC_LSB;
    end else if (grant_valid) begin
      last_grant <= grant_src;
    end
  end

  // Without a grant only valid drops; payload holds so consumers see no glitching.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bus.cdb_valid_out  <= 1'b0;
      bus.cdb_src_out    <= 1'b0;
      bus.cdb_tag_out    <= '0;
      bus.cdb_data_out   <= '0;
      bus.cdb_jump_out   <= 1'b0;
      bus.cdb_target_out <= '0;
    end else if (grant_valid) begin
      bus.cdb_valid_out  <= 1'b1;
      bus.cdb_src_out    <= grant_src;
      bus.cdb_tag_out    <= grant_entry.tag;
      bus.cdb_data_out   <= grant_entry.data;
      bus.cdb_jump_out   <= grant_entry.jump;
      bus.cdb_target_out <= grant_entry.target;
    end else begin
      bus.cdb_valid_out  <= 1'b0;
    end
  end

  count_bound_a : assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (alu_count <= FULL_CNT) && (lsb_count <= FULL_CNT));

  no_starve_a : assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (grant_valid && alu_nonempty && lsb_nonempty) |-> (grant_src != last_grant));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: hand sequences, a constant vector table
// and a randomized run against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int TAG_W  = 5;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rdy;
  logic clr;

  cdb_arbiter_if #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .rdy_in   (rdy),
    .clear_in (clr),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus encoding used by the vector table: payload fields follow from the tag.
  function automatic logic [DATA_W-1:0] alu_data_of(input logic [TAG_W-1:0] t);
    return 32'h100 + DATA_W'(t);
  endfunction
  function automatic logic [ADDR_W-1:0] alu_tgt_of(input logic [TAG_W-1:0] t);
    return 32'h8000_0000 | ADDR_W'(t);
  endfunction
  function automatic logic [DATA_W-1:0] lsb_data_of(input logic [TAG_W-1:0] t);
    return 32'h200 + DATA_W'(t);
  endfunction

  task automatic drive(input logic r, input logic c,
                       input logic av, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
                       input logic aj, input logic [ADDR_W-1:0] atg,
                       input logic lv, input logic [TAG_W-1:0] lt, input logic [DATA_W-1:0] ld);
    rdy               = r;
    clr               = c;
    bus.alu_valid_in  = av;
    bus.alu_tag_in    = at;
    bus.alu_data_in   = ad;
    bus.alu_jump_in   = aj;
    bus.alu_target_in = atg;
    bus.lsb_valid_in  = lv;
    bus.lsb_tag_in    = lt;
    bus.lsb_data_in   = ld;
  endtask

  task automatic drive_idle();
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic rdy, clr;
    logic av;  logic [TAG_W-1:0] at;
    logic lv;  logic [TAG_W-1:0] lt;
    logic e_ardy, e_lrdy;
    logic e_valid, e_src; logic [TAG_W-1:0] e_tag;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic c,
                              input logic av, input int at, input logic lv, input int lt,
                              input logic ea, input logic el,
                              input logic ev, input logic es, input int et);
    vec_t v;
    v.rdy = r; v.clr = c;
    v.av = av; v.at = TAG_W'(at);
    v.lv = lv; v.lt = TAG_W'(lt);
    v.e_ardy = ea; v.e_lrdy = el;
    v.e_valid = ev; v.e_src = es; v.e_tag = TAG_W'(et);
    return v;
  endfunction

  vec_t vt [21];

  // ---------------------------------------------------------- reference model
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [ADDR_W-1:0] target;
  } ent_t;

  ent_t qa [$];
  ent_t ql [$];
  int                m_last;
  logic              m_valid, m_src, m_jump;
  logic [TAG_W-1:0]  m_tag;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_target;

  task automatic model_reset();
    qa.delete();
    ql.delete();
    m_last = 1;
    m_valid = 1'b0; m_src = 1'b0; m_jump = 1'b0;
    m_tag = '0; m_data = '0; m_target = '0;
  endtask

  function automatic logic model_ready(input int fill);
    return rdy && !clr && (fill < DEPTH);
  endfunction

  // One clock edge: grant from the pre-edge queues, then accept offered entries.
  task automatic model_edge();
    logic ra, rl;
    int   g;
    ent_t e;
    ra = model_ready(qa.size());
    rl = model_ready(ql.size());
    if (clr) begin
      qa.delete();
      ql.delete();
      m_valid = 1'b0;
    end else if (!rdy) begin
      m_valid = 1'b0;
    end else begin
      g = -1;
      if (qa.size() > 0 && ql.size() > 0) g = 1 - m_last;
      else if (qa.size() > 0)             g = 0;
      else if (ql.size() > 0)             g = 1;
      if (g >= 0) begin
        e = (g == 0) ? qa.pop_front() : ql.pop_front();
        m_valid = 1'b1; m_src = (g == 1);
        m_tag = e.tag; m_data = e.data; m_jump = e.jump; m_target = e.target;
        m_last = g;
      end else begin
        m_valid = 1'b0;
      end
      if (bus.alu_valid_in && ra)
        qa.push_back('{bus.alu_tag_in, bus.alu_data_in, bus.alu_jump_in, bus.alu_target_in});
      if (bus.lsb_valid_in && rl)
        ql.push_back('{bus.lsb_tag_in, bus.lsb_data_in, 1'b0, '0});
    end
  endtask

  task automatic check_model_outputs();
    check("rnd_valid",  bus.cdb_valid_out,  m_valid);
    check("rnd_src",    bus.cdb_src_out,    m_src);
    check("rnd_tag",    bus.cdb_tag_out,    m_tag);
    check("rnd_data",   bus.cdb_data_out,   m_data);
    check("rnd_jump",   bus.cdb_jump_out,   m_jump);
    check("rnd_target", bus.cdb_target_out, m_target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0;
    rdy = 1'b1;
    rst_n = 1'b1;
    drive_idle();
    #2;
    apply_reset();

    // -------- reset state
    check("rst_valid",  bus.cdb_valid_out,  1'b0);
    check("rst_src",    bus.cdb_src_out,    1'b0);
    check("rst_tag",    bus.cdb_tag_out,    '0);
    check("rst_data",   bus.cdb_data_out,   '0);
    check("rst_jump",   bus.cdb_jump_out,   1'b0);
    check("rst_target", bus.cdb_target_out, '0);
    check("rst_ardy",   bus.alu_ready_out,  1'b1);
    check("rst_lrdy",   bus.lsb_ready_out,  1'b1);

    // -------- single ALU request: accepted at edge 1, visible after edge 2 only
    drive(1'b1, 1'b0, 1'b1, 5'd3, 32'h11, 1'b1, 32'h0000_4000, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("single_e1_valid", bus.cdb_valid_out, 1'b0);
    drive_idle();
    @(posedge clk); #1;
    check("single_e2_valid",  bus.cdb_valid_out,  1'b1);
    check("single_e2_src",    bus.cdb_src_out,    1'b0);
    check("single_e2_tag",    bus.cdb_tag_out,    5'd3);
    check("single_e2_data",   bus.cdb_data_out,   32'h11);
    check("single_e2_jump",   bus.cdb_jump_out,   1'b1);
    check("single_e2_target", bus.cdb_target_out, 32'h0000_4000);
    @(posedge clk); #1;
    check("single_e3_valid", bus.cdb_valid_out, 1'b0);
    check("single_e3_hold",  bus.cdb_tag_out,   5'd3);

    // -------- vector table, from a fresh reset (last_grant = LSB)
    //         rdy clr av at  lv lt   ardy lrdy  valid src tag
    vt[0]  = mk(1, 0, 1, 1,  1, 2,   1, 1,   0, 0, 0);   // simultaneous enqueue
    vt[1]  = mk(1, 0, 0, 0,  0, 0,   1, 1,   1, 0, 1);   // ALU wins the first tie
    vt[2]  = mk(1, 0, 0, 0,  0, 0,   1, 1,   1, 1, 2);
    vt[3]  = mk(1, 0, 0, 0,  0, 0,   1, 1,   0, 0, 0);
    vt[4]  = mk(1, 0, 1, 10, 1, 20,  1, 1,   0, 0, 0);   // both offer every cycle
    vt[5]  = mk(1, 0, 1, 11, 1, 21,  1, 1,   1, 0, 10);
    vt[6]  = mk(1, 0, 1, 12, 1, 22,  1, 0,   1, 1, 20);  // LSB full after two accepts
    vt[7]  = mk(1, 0, 1, 13, 1, 22,  0, 1,   1, 0, 11);
    vt[8]  = mk(1, 0, 1, 13, 1, 23,  1, 0,   1, 1, 21);
    vt[9]  = mk(1, 0, 1, 14, 1, 23,  0, 1,   1, 0, 12);
    vt[10] = mk(1, 0, 1, 14, 1, 24,  1, 0,   1, 1, 22);
    vt[11] = mk(1, 0, 1, 15, 1, 24,  0, 1,   1, 0, 13);
    vt[12] = mk(1, 1, 1, 15, 1, 25,  0, 0,   0, 0, 0);   // flush
    vt[13] = mk(1, 0, 0, 0,  0, 0,   1, 1,   0, 0, 0);
    vt[14] = mk(1, 0, 0, 0,  0, 0,   1, 1,   0, 0, 0);
    vt[15] = mk(1, 0, 1, 7,  0, 0,   1, 1,   0, 0, 0);   // one pending entry
    vt[16] = mk(0, 0, 0, 0,  0, 0,   0, 0,   0, 0, 0);   // frozen
    vt[17] = mk(0, 0, 1, 9,  1, 9,   0, 0,   0, 0, 0);
    vt[18] = mk(0, 0, 0, 0,  0, 0,   0, 0,   0, 0, 0);
    vt[19] = mk(1, 0, 0, 0,  0, 0,   1, 1,   1, 0, 7);   // released
    vt[20] = mk(1, 0, 0, 0,  0, 0,   1, 1,   0, 0, 0);

    apply_reset();
    for (int i = 0; i < 21; i++) begin
      drive(vt[i].rdy, vt[i].clr,
            vt[i].av, vt[i].at, alu_data_of(vt[i].at), vt[i].at[0], alu_tgt_of(vt[i].at),
            vt[i].lv, vt[i].lt, lsb_data_of(vt[i].lt));
      #1;
      check($sformatf("vec%0d_ardy", i), bus.alu_ready_out, vt[i].e_ardy);
      check($sformatf("vec%0d_lrdy", i), bus.lsb_ready_out, vt[i].e_lrdy);
      @(posedge clk); #1;
      check($sformatf("vec%0d_valid", i), bus.cdb_valid_out, vt[i].e_valid);
      if (vt[i].e_valid) begin
        check($sformatf("vec%0d_src", i), bus.cdb_src_out, vt[i].e_src);
        check($sformatf("vec%0d_tag", i), bus.cdb_tag_out, vt[i].e_tag);
        check($sformatf("vec%0d_data", i), bus.cdb_data_out,
              vt[i].e_src ? lsb_data_of(vt[i].e_tag) : alu_data_of(vt[i].e_tag));
        check($sformatf("vec%0d_jump", i), bus.cdb_jump_out,
              vt[i].e_src ? 1'b0 : vt[i].e_tag[0]);
        check($sformatf("vec%0d_target", i), bus.cdb_target_out,
              vt[i].e_src ? '0 : alu_tgt_of(vt[i].e_tag));
      end
    end

    // -------- asynchronous reset between edges while a broadcast is visible
    apply_reset();
    drive(1'b1, 1'b0, 1'b1, 5'd5, 32'h55, 1'b0, '0, 1'b1, 5'd6, 32'h66);
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    check("arst_pre_valid", bus.cdb_valid_out, 1'b1);
    check("arst_pre_tag",   bus.cdb_tag_out,   5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.cdb_valid_out, 1'b0);
    check("arst_tag",   bus.cdb_tag_out,   '0);
    check("arst_data",  bus.cdb_data_out,  '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ardy", bus.alu_ready_out, 1'b1);
    check("arst_lrdy", bus.lsb_ready_out, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      check("arst_lost", bus.cdb_valid_out, 1'b0);
    end

    // -------- randomized run against the reference model
    apply_reset();
    model_reset();
    check_model_outputs();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 9) < 6), TAG_W'($urandom), $urandom, 1'($urandom), $urandom,
            ($urandom_range(0, 9) < 6), TAG_W'($urandom), $urandom);
      #1;
      check("rnd_ardy", bus.alu_ready_out, model_ready(qa.size()));
      check("rnd_lrdy", bus.lsb_ready_out, model_ready(ql.size()));
      model_edge();
      @(posedge clk); #1;
      check_model_outputs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
